// File: rtl/alu_acc_pkg.sv
// Shared definitions for the accumulator ALU with scanning hex display.
// Op codes and active-low {g,f,e,d,c,b,a} segment patterns.
package alu_acc_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_SLL  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry n is the pattern for hex digit n (index 15 listed first).
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110, // F
        7'b0000110, // E
        7'b0100001, // d
        7'b1000110, // C
        7'b0000011, // b
        7'b0001000, // A
        7'b0010000, // 9
        7'b0000000, // 8
        7'b1111000, // 7
        7'b0000010, // 6
        7'b0010010, // 5
        7'b0011001, // 4
        7'b0110000, // 3
        7'b0100100, // 2
        7'b1111001, // 1
        7'b1000000  // 0
    };

    function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module seg7_hex_decoder
    import alu_acc_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_pattern(nibble);
    end

endmodule

// File: rtl/alu_acc_seg.sv
// Registered accumulator ALU with carry/overflow/zero flags and a
// time-multiplexed multi-digit hex display with one-hot active-low anodes.
module alu_acc_seg
    import alu_acc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  num1,
    output logic [WIDTH-1:0]  ans,
    output logic              zero,
    output logic              carry,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (4 * DIGITS > WIDTH) ? 4 * DIGITS : WIDTH;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] IDX_LAST = DW'(DIGITS - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             a_msb;
    logic             b_msb;

    logic [CW-1:0]    cnt;
    logic [DW-1:0]    idx;
    logic [PW-1:0]    padded;
    logic [3:0]       nibble;
    logic             hit;
    logic [6:0]       dec_seg;

    // ---------------- ALU ----------------
    assign sum   = {1'b0, acc} + {1'b0, num1};
    assign diff  = {1'b0, acc} - {1'b0, num1};
    assign a_msb = acc[WIDTH-1];
    assign b_msb = num1[WIDTH-1];

    always_comb begin
        res   = acc;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (op)
            OP_LOAD: res = num1;
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
            end
            OP_SUB: begin
                // diff[WIDTH] is the borrow out of the unsigned subtract
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
            end
            OP_AND: res = acc & num1;
            OP_OR:  res = acc | num1;
            OP_XOR: res = acc ^ num1;
            OP_SLL: res = acc << num1[SW-1:0];
            OP_CLR: res = '0;
            default: res = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            acc   <= res;
            carry <= res_c;
            ovf   <= res_v;
        end
    end

    assign ans  = acc;
    assign zero = (acc == '0);

    // ---------------- display scan ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Nibbles above WIDTH read as zero via the zero-extended copy.
    always_comb begin
        padded = PW'(acc);
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == DW'(i)) begin
                nibble = padded[4*i +: 4];
                hit    = 1'b1;
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        an  = ~(DIGITS'(1) << idx);
        seg = hit ? dec_seg : SEG_BLANK;
    end

endmodule
